// File: rtl/conv_row_engine.sv
// Row-streaming 3x3 / 1x1 / fused convolution engine with a partial-row accumulator.
// Optional ReLU on the drained result when CONV_ROW_RELU_EN is defined.
module conv_row_engine #(
    parameter int DW      = 32,
    parameter int FW      = 8,
    parameter int ROW_W   = 56,
    parameter int CIN_NUM = 64,
    parameter int ACC_W   = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic            wht_we,
    input  logic [3:0]      wht_addr,
    input  logic [DW-1:0]   wht_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*DW-1:0] in_col,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last
);
    localparam int IW  = (ROW_W > 1) ? $clog2(ROW_W) : 1;
    localparam int CNW = (CIN_NUM > 1) ? $clog2(CIN_NUM) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_e;

    state_e                   state_q, state_d;
    logic                     flush_hold_q, flush_hold_d;
    logic [IW-1:0]            col_cnt_q, col_cnt_d;
    logic [CNW-1:0]           cin_cnt_q, cin_cnt_d;
    logic [3*DW-1:0]          c0_q, c0_d, c1_q, c1_d;
    logic [1:0]               mode_q, mode_d;
    logic [DW-1:0]            w_q [10];
    logic [DW-1:0]            w_d [10];
    logic                     s_valid_q, s_valid_d;
    logic [IW-1:0]            s_idx_q, s_idx_d;
    logic                     s_first_q, s_first_d;
    logic signed [ACC_W-1:0]  s_sum_q, s_sum_d;
    logic signed [ACC_W-1:0]  acc_q [ROW_W];
    logic signed [ACC_W-1:0]  acc_d [ROW_W];

    logic                     accept, last_col, last_cin;
    logic [3*DW-1:0]          win [3];
    logic signed [ACC_W-1:0]  sum3, sum1, rd_acc;
    logic [DW-1:0]            result;

    // Full signed product, floor-shifted by FW, then fitted to the accumulator width.
    function automatic logic signed [ACC_W-1:0] fx_mul(input logic signed [DW-1:0] a,
                                                       input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        p = p >>> FW;
        return ACC_W'(p);
    endfunction

    assign accept   = in_valid && in_ready;
    assign last_col = (col_cnt_q == IW'(ROW_W - 1));
    assign last_cin = (cin_cnt_q == CNW'(CIN_NUM - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            flush_hold_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_hold_q <= flush_hold_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // The last channel's FLUSH holds one extra cycle so the final acc write lands before DRAIN.
    always_comb begin
        state_d      = state_q;
        flush_hold_d = 1'b0;
        unique case (state_q)
            IDLE:  if (accept) state_d = RUN;
            RUN:   if (accept && last_col) state_d = FLUSH;
            FLUSH: begin
                if (!last_cin)          state_d = IDLE;
                else if (!flush_hold_q) flush_hold_d = 1'b1;
                else                    state_d = DRAIN;
            end
            DRAIN: if (out_ready && last_col) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == RUN);
        out_valid = (state_q == DRAIN);
        out_last  = (state_q == DRAIN) && last_col;
        out_data  = (state_q == DRAIN) ? result : '0;
    end

    // ---------------- control counters, window, weights ----------------
    always_comb begin
        col_cnt_d = col_cnt_q;
        cin_cnt_d = cin_cnt_q;
        c0_d      = c0_q;
        c1_d      = c1_q;
        mode_d    = mode_q;
        w_d       = w_q;
        if (state_q == IDLE && wht_we && wht_addr <= 4'd9)
            w_d[wht_addr] = wht_i;
        unique case (state_q)
            IDLE: if (accept) begin
                c0_d      = '0;
                c1_d      = in_col;
                col_cnt_d = IW'(1);
                if (cin_cnt_q == '0) mode_d = mode;
            end
            RUN: if (accept) begin
                c0_d      = c1_q;
                c1_d      = in_col;
                col_cnt_d = last_col ? '0 : col_cnt_q + IW'(1);
            end
            FLUSH: if (!flush_hold_q && !last_cin) cin_cnt_d = cin_cnt_q + CNW'(1);
            DRAIN: if (out_ready) begin
                if (last_col) begin
                    col_cnt_d = '0;
                    cin_cnt_d = '0;
                end else begin
                    col_cnt_d = col_cnt_q + IW'(1);
                end
            end
            default: ;
        endcase
    end

    // ---------------- product/sum stage and accumulator ----------------
    always_comb begin
        win[0] = c0_q;
        win[1] = c1_q;
        win[2] = (state_q == FLUSH) ? '0 : in_col;
        sum3   = '0;
        for (int unsigned r = 0; r < 3; r++)
            for (int unsigned c = 0; c < 3; c++)
                sum3 = sum3 + fx_mul(w_q[3*r+c], win[c][r*DW +: DW]);
        sum1 = fx_mul(w_q[9], c1_q[DW +: DW]);
        unique case (mode_q)
            2'd0:    s_sum_d = sum3;
            2'd1:    s_sum_d = sum1;
            default: s_sum_d = sum3 + sum1;
        endcase
        s_valid_d = (state_q == RUN && accept) || (state_q == FLUSH && !flush_hold_q);
        s_idx_d   = (state_q == FLUSH) ? IW'(ROW_W - 1) : col_cnt_q - IW'(1);
        s_first_d = (cin_cnt_q == '0);

        acc_d = acc_q;
        if (s_valid_q)
            acc_d[s_idx_q] = s_first_q ? s_sum_q : acc_q[s_idx_q] + s_sum_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q <= '0;
            cin_cnt_q <= '0;
            c0_q      <= '0;
            c1_q      <= '0;
            mode_q    <= '0;
            s_valid_q <= 1'b0;
            s_idx_q   <= '0;
            s_first_q <= 1'b0;
            s_sum_q   <= '0;
            for (int unsigned i = 0; i < 10; i++)    w_q[i]   <= '0;
            for (int unsigned i = 0; i < ROW_W; i++) acc_q[i] <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            cin_cnt_q <= cin_cnt_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            mode_q    <= mode_d;
            s_valid_q <= s_valid_d;
            s_idx_q   <= s_idx_d;
            s_first_q <= s_first_d;
            s_sum_q   <= s_sum_d;
            w_q       <= w_d;
            acc_q     <= acc_d;
        end
    end

    // ---------------- saturation / optional ReLU ----------------
    always_comb begin
        rd_acc = acc_q[col_cnt_q];
        if (&rd_acc[ACC_W-1:DW-1] || ~|rd_acc[ACC_W-1:DW-1])
            result = rd_acc[DW-1:0];
        else
            result = rd_acc[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`ifdef CONV_ROW_RELU_EN
        if (result[DW-1]) result = '0;
`else
`endif
    end

endmodule

// File: tb/tb_conv_row_engine.sv
// Directed self-checking bench for conv_row_engine (ROW_W=4, CIN_NUM=2).
module tb_conv_row_engine;
    localparam int DW      = 32;
    localparam int FW      = 8;
    localparam int ROW_W   = 4;
    localparam int CIN_NUM = 2;
    localparam int ACC_W   = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mode;
    logic            wht_we;
    logic [3:0]      wht_addr;
    logic [DW-1:0]   wht_i;
    logic            in_valid;
    logic            in_ready;
    logic [3*DW-1:0] in_col;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;

    int n_checks = 0;
    int n_fail   = 0;
    int ex [4];

    always #5 clk = ~clk;

    conv_row_engine #(.DW(DW), .FW(FW), .ROW_W(ROW_W), .CIN_NUM(CIN_NUM), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .wht_we(wht_we), .wht_addr(wht_addr), .wht_i(wht_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3*DW-1:0] col3(input logic [DW-1:0] v);
        return {v, v, v};
    endfunction

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic load_w(input int w3, input int w1);
        wait_ready("idle_wait");
        for (int a = 0; a < 10; a++) begin
            wht_we   = 1'b1;
            wht_addr = 4'(a);
            wht_i    = (a < 9) ? w3 : w1;
            @(negedge clk);
        end
        wht_we = 1'b0;
    endtask

    // Sends one channel of ROW_W columns; optional dropped weight write and mode-pin change.
    task automatic send_row(input logic [DW-1:0] v, input bit glitch,
                            input bit chg_mode, input logic [1:0] mode_new);
        for (int k = 0; k < ROW_W; k++) begin
            in_valid = 1'b1;
            in_col   = col3(v);
            if (glitch && k == 2) begin
                wht_we = 1'b1; wht_addr = 4'd4; wht_i = '0;
            end
            wait_ready("accept_wait");
            @(negedge clk);
            wht_we = 1'b0;
            if (chg_mode && k == 0) mode = mode_new;
        end
        in_valid = 1'b0;
        in_col   = '0;
    endtask

    task automatic drain(input string tag, input logic [3:0] rdy);
        int n = 0;
        int cyc = 0;
        while (n < ROW_W && cyc < 100) begin
            out_ready = rdy[cyc % 4];
            if (out_valid) begin
                check($sformatf("%s_data%0d", tag, n), out_data, ex[n]);
                check($sformatf("%s_last%0d", tag, n), {31'b0, out_last}, {31'b0, (n == ROW_W-1)});
                if (out_ready) n++;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_count"}, 32'(n), 32'(ROW_W));
        out_ready = 1'b1;
        check({tag, "_done"}, {31'b0, out_valid}, 32'd0);
    endtask

    function automatic int relu(input int v);
`ifdef CONV_ROW_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 2'd0; wht_we = 1'b0; wht_addr = '0; wht_i = '0;
        in_valid = 1'b0; in_col = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_out_last",  {31'b0, out_last},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, ones; mode pin changed mid-row must be ignored. Channel 1 zeros.
        mode = 2'd0;
        load_w(256, 256);
        send_row(32'd256, 1'b0, 1'b1, 2'd1);
        send_row(32'd0, 1'b0, 1'b0, 2'd0);
        ex = '{1536, 2304, 2304, 1536};
        drain("m0", 4'b1111);

        mode = 2'd2;
        load_w(256, 256);
        send_row(32'd256, 1'b0, 1'b0, 2'd0);
        send_row(32'd0, 1'b0, 1'b0, 2'd0);
        ex = '{1792, 2560, 2560, 1792};
        drain("m2", 4'b1111);

        mode = 2'd1;
        load_w(256, 256);
        send_row(32'd256, 1'b0, 1'b0, 2'd0);
        send_row(32'd0, 1'b0, 1'b0, 2'd0);
        ex = '{256, 256, 256, 256};
        drain("m1", 4'b1111);

        // Two live channels, weights rewritten between them, dropped write during RUN.
        mode = 2'd2;
        load_w(256, 256);
        send_row(32'd256, 1'b0, 1'b0, 2'd0);
        load_w(256, 256);
        send_row(32'd256, 1'b1, 1'b0, 2'd0);
        ex = '{3584, 5120, 5120, 3584};
        drain("cin2", 4'b1111);

        mode = 2'd0;
        load_w(-256, 0);
        send_row(32'd256, 1'b0, 1'b0, 2'd0);
        send_row(32'd0, 1'b0, 1'b0, 2'd0);
        ex = '{relu(-1536), relu(-2304), relu(-2304), relu(-1536)};
        drain("neg", 4'b1111);

        load_w(256, 0);
        send_row(32'h7FFF0000, 1'b0, 1'b0, 2'd0);
        send_row(32'd0, 1'b0, 1'b0, 2'd0);
        ex = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        drain("satp", 4'b1111);

        load_w(256, 0);
        send_row(32'h80000000, 1'b0, 1'b0, 2'd0);
        send_row(32'd0, 1'b0, 1'b0, 2'd0);
        ex = '{relu(32'h80000000), relu(32'h80000000), relu(32'h80000000), relu(32'h80000000)};
        drain("satn", 4'b1111);

        // Backpressure: ready pattern 1,0,0,1 per cycle.
        load_w(256, 0);
        send_row(32'd256, 1'b0, 1'b0, 2'd0);
        send_row(32'd0, 1'b0, 1'b0, 2'd0);
        ex = '{1536, 2304, 2304, 1536};
        drain("bp", 4'b1001);

        // Reset mid-RUN, then a clean row.
        load_w(256, 0);
        in_valid = 1'b1;
        in_col   = col3(32'd256);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        load_w(256, 0);
        send_row(32'd256, 1'b0, 1'b0, 2'd0);
        send_row(32'd0, 1'b0, 1'b0, 2'd0);
        ex = '{1536, 2304, 2304, 1536};
        drain("post_rst", 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_row_engine.md
# conv_row_engine

Parametrised row-streaming convolution engine for the RepVGG accelerator: computes one output row of one output channel for a 3x3 conv, a 1x1 conv, or their fused sum (training-form RepVGG block), with zero padding. It accumulates partial rows over `CIN_NUM` input channels in an internal row buffer. It then drains the finished row with saturation and optional ReLU. It replaces the fixed 8-PE 56-wide arrangement with one engine generalised in row width, channel count and mode.

## Interface
- `DW`, 32, data width of fmap, weight and result words (signed fixed point)
- `FW`, 8, fractional bits; integer bits = `DW-FW`
- `ROW_W`, 56, output/input row width in columns (>=2)
- `CIN_NUM`, 64, input channels accumulated per output row
- `ACC_W`, 40, accumulator width (>= DW)
- `clk` in 1 — the single clock.
- `rst` in 1 — asynchronous, active-high reset.
- `mode` in 2 — conv mode: 0 = 3x3, 1 = 1x1, 2 or 3 = fused (3x3 + 1x1). Sampled on the first accepted column of channel 0.
- `wht_we` in 1 — weight write strobe.
- `wht_addr` in 4 — weight address: 0..8 = 3x3 weights row-major (`w[r][c]` at `3r+c`), 9 = 1x1 weight, 10..15 ignored.
- `wht_i` in DW — weight data.
- `in_valid` in 1, `in_ready` out 1 — input column handshake.
- `in_col` in 3*DW — one input column: `[DW-1:0]` = row r-1, `[2DW-1:DW]` = row r, `[3DW-1:2DW]` = row r+1. Upstream supplies zeros for top/bottom padding.
- `out_valid` out 1, `out_ready` in 1 — output handshake.
- `out_data` out DW — result word.
- `out_last` out 1 — high with column ROW_W-1.

## Operation
- States: IDLE, RUN, FLUSH, DRAIN.
- IDLE
  - `in_ready`=1.
  - `wht_we` writes are accepted only in IDLE. Writes in any other state are dropped.
  - An accepted column goes to RUN with `col_cnt`=1.
- RUN
  - `in_ready`=1.
  - The window holds `c0` (column k-2, zero when k-1==0) and `c1` (column k-1). Accepting column k as `c2` computes output index k-1.
  - 3x3 term: sum over r,c of `w[r][c]*win[c][r]`.
  - 1x1 term: `w1x1*c1[1]`.
  - Mode selects the 3x3 term, the 1x1 term, or their sum.
  - After column ROW_W-1 is accepted, go to FLUSH.
- FLUSH
  - `in_ready`=0.
  - Computes index ROW_W-1 with `c2`=0 (right pad).
  - Then `cin_cnt`++.
  - If `cin_cnt` was CIN_NUM-1, go to DRAIN. Otherwise go to IDLE (awaiting the next channel's weights and columns).
- Arithmetic
  - Each product is a full 2*DW signed product, arithmetic-shifted right by FW (truncate toward -inf), then sign-extended to ACC_W.
  - Partial row buffer `acc[ROW_W]`: at `cin_cnt`==0 write `acc=partial`, else `acc+=partial`. Wraps at ACC_W with no saturation internally.
- DRAIN
  - Presents `acc[j]` for j=0..ROW_W-1, saturated to signed DW (`2^(DW-1)-1` / `-2^(DW-1)`).
  - Advances on `out_valid && out_ready`.
  - After `out_last` transfers: `cin_cnt`=0, go to IDLE.
- Weights persist until overwritten or reset.
- `mode` is held internally for the whole output row; changes to the `mode` pin mid-row are ignored.
- Reset (at any time, including mid-row or mid-drain)
  - State goes to IDLE; counters, window, weights and acc are cleared to 0.
  - Any partial row is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0.
- Pipeline: one registered product/sum stage, then acc write the following cycle. An index computed in cycle t is in acc at t+2.
- One channel occupies ROW_W accept cycles plus 1 FLUSH cycle.
- Back-to-back channels: IDLE accepts a column on the first IDLE cycle (minimum 1 bubble cycle per channel, used for weight writes).
- DRAIN begins 2 cycles after the final FLUSH.
  - `out_valid` rises on the first DRAIN cycle.
  - `out_data`/`out_last` stay stable while `out_valid && !out_ready`.
  - Throughput is 1 word/cycle with `out_ready`=1.
- `in_ready`=0 throughout FLUSH and DRAIN. `in_valid` there is ignored.
- `wht_we` in the same cycle as an accepted IDLE column: the write lands, and the column uses the new weight.

## Configuration
- `CONV_ROW_RELU_EN` defined: after saturation, negative results output as 0 (RepVGG block ReLU).
- Undefined: the saturated signed value is output unchanged.

## Test plan
- Mode 0, ROW_W=4, CIN_NUM=1, all weights 1.0 (256), all inputs 1.0 -> `out_data` = 1536, 2304, 2304, 1536 and `out_last` on the 4th word.
- Same stimulus, mode 2 -> 1792, 2560, 2560, 1792. Mode 1 -> 256 ×4.
- CIN_NUM=2, mode 2, same data both channels, weights rewritten in IDLE between channels -> 3584, 5120, 5120, 3584. A `wht_we` pulse during RUN must leave results unchanged.
- 3x3 weights -1.0, mode 0, inputs 1.0 -> with `CONV_ROW_RELU_EN`: all 0. Without it: -1536, -2304, -2304, -1536. Input 0x7FFF0000 with weights 1.0 -> 0x7FFFFFFF.
- DRAIN with `out_ready` toggling 1,0,0,1 -> each word held stable until transferred, no loss or duplication.
- `rst` asserted mid-RUN, then a full mode-0 row with reloaded weights -> results identical to scenario 1, with no residue from the aborted row.
